// File: rtl/rename_tag_allocator_if.sv
// rtl/rename_tag_allocator_if.sv - alloc/free/checkpoint bus of the rename tag free list
interface rename_tag_allocator_if #(
  parameter int RN_COUNT = 64
);
  localparam int TW = $clog2(RN_COUNT);

  logic [1:0]    alloc_req;
  logic          stall;
  logic [1:0]    alloc_valid;
  logic [TW-1:0] alloc_tag_0;
  logic [TW-1:0] alloc_tag_1;
  logic [1:0]    free_valid;
  logic [TW-1:0] free_tag_0;
  logic [TW-1:0] free_tag_1;
  logic          checkpoint;
  logic          flush;
  logic          ready;
  logic [TW:0]   free_count;
  logic          overflow;

  modport master (
    output alloc_req, free_valid, free_tag_0, free_tag_1, checkpoint, flush,
    input  stall, alloc_valid, alloc_tag_0, alloc_tag_1, ready, free_count, overflow
  );

  modport slave (
    input  alloc_req, free_valid, free_tag_0, free_tag_1, checkpoint, flush,
    output stall, alloc_valid, alloc_tag_0, alloc_tag_1, ready, free_count, overflow
  );
endinterface

// File: rtl/rename_tag_allocator.sv
// rtl/rename_tag_allocator.sv - rename tag free list: dual pop/push circular FIFO with one branch checkpoint
module rename_tag_allocator #(
  parameter int XLEN     = 32,
  parameter int RN_COUNT = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  rename_tag_allocator_if.slave bus
);
  localparam int TW    = $clog2(RN_COUNT);
  localparam int DEPTH = RN_COUNT - 1;
  localparam logic [TW-1:0] LAST_PTR = TW'(DEPTH - 1);
  localparam logic [TW-1:0] LAST_TAG = TW'(DEPTH);
  localparam logic [TW:0]   FULL     = (TW+1)'(DEPTH);

  if (XLEN < 1) begin : g_xlen_check
    $error("XLEN must be positive");
  end

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t state_q, state_d;
  logic   init_done;

  logic [TW-1:0] fifo [DEPTH];
  logic [TW-1:0] head_q, tail_q, ckpt_head_q, init_cnt_q;
  logic [TW:0]   count_q, since_ckpt_q;
  logic [1:0]    alloc_valid_q;
  logic [TW-1:0] tag0_q, tag1_q;
  logic          overflow_q;

  logic          run, do_alloc, flush_run, ck_take;
  logic [TW:0]   need, pop_n, base, freed, count_next, since_next;
  logic [TW-1:0] head_one, head_two, head_next, slot1_ptr, tail1_ptr, tail_next;
  logic          f0, f1, acc0, acc1, drop;

  // List length is not a power of two, so pointers wrap explicitly.
  function automatic logic [TW-1:0] ptr_inc(input logic [TW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    init_done = 1'b0;
    if (state_q == ST_INIT && init_cnt_q == LAST_TAG) begin
      state_d   = ST_RUN;
      init_done = 1'b1;
    end
  end

  always_comb begin
    run       = (state_q == ST_RUN);
    flush_run = run && bus.flush;
    ck_take   = run && bus.checkpoint && !bus.flush;
    need      = {{TW{1'b0}}, bus.alloc_req[0]} + {{TW{1'b0}}, bus.alloc_req[1]};
    // Availability uses the registered count only; same-cycle frees help next cycle.
    bus.stall = !run || (need > count_q);
    do_alloc  = run && !bus.stall && !bus.flush;
    pop_n     = do_alloc ? need : '0;

    head_one  = ptr_inc(head_q);
    head_two  = ptr_inc(head_one);
    slot1_ptr = bus.alloc_req[0] ? head_one : head_q;
    head_next = head_q;
    if (do_alloc) begin
      if (bus.alloc_req == 2'b11)      head_next = head_two;
      else if (bus.alloc_req != 2'b00) head_next = head_one;
    end

    // On flush the rewound entries are back in the list before frees are counted.
    base  = flush_run ? count_q + since_ckpt_q : count_q;
    f0    = run && bus.free_valid[0] && (bus.free_tag_0 != '0);
    f1    = run && bus.free_valid[1] && (bus.free_tag_1 != '0);
    acc0  = f0 && (base < FULL);
    acc1  = f1 && ((base + {{TW{1'b0}}, acc0}) < FULL);
    drop  = (f0 && !acc0) || (f1 && !acc1);
    freed = {{TW{1'b0}}, acc0} + {{TW{1'b0}}, acc1};

    tail1_ptr = acc0 ? ptr_inc(tail_q) : tail_q;
    tail_next = acc1 ? ptr_inc(tail1_ptr) : tail1_ptr;

    count_next = base - pop_n + freed;
    since_next = (flush_run || ck_take) ? '0 : since_ckpt_q + pop_n;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q        <= '0;
      tail_q        <= '0;
      ckpt_head_q   <= '0;
      count_q       <= '0;
      since_ckpt_q  <= '0;
      init_cnt_q    <= TW'(1);
      alloc_valid_q <= '0;
      tag0_q        <= '0;
      tag1_q        <= '0;
      overflow_q    <= 1'b0;
    end else if (state_q == ST_INIT) begin
      init_cnt_q <= init_cnt_q + 1'b1;
      if (init_done) begin
        count_q <= FULL;
        tail_q  <= '0;
      end
    end else begin
      head_q        <= flush_run ? ckpt_head_q : head_next;
      tail_q        <= tail_next;
      count_q       <= count_next;
      since_ckpt_q  <= since_next;
      alloc_valid_q <= do_alloc ? bus.alloc_req : 2'b00;
      if (ck_take) ckpt_head_q <= head_next;
      if (do_alloc && bus.alloc_req[0]) tag0_q <= fifo[head_q];
      if (do_alloc && bus.alloc_req[1]) tag1_q <= fifo[slot1_ptr];
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Popped entries are never erased, so rewinding head restores them.
  always_ff @(posedge clock) begin
    if (state_q == ST_INIT) begin
      fifo[init_cnt_q - 1'b1] <= init_cnt_q;
    end else begin
      if (acc0) fifo[tail_q]    <= bus.free_tag_0;
      if (acc1) fifo[tail1_ptr] <= bus.free_tag_1;
    end
  end

  assign bus.alloc_valid = alloc_valid_q;
  assign bus.alloc_tag_0 = tag0_q;
  assign bus.alloc_tag_1 = tag1_q;
  assign bus.ready       = run;
  assign bus.free_count  = count_q;
  assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_rename_tag_allocator.sv
// tb/tb_rename_tag_allocator.sv - directed and randomized checks of rename_tag_allocator against a queue model
module tb_rename_tag_allocator;
  localparam int RN_COUNT = 64;
  localparam int TW       = 6;
  localparam int DEPTH    = RN_COUNT - 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  rename_tag_allocator_if #(.RN_COUNT(RN_COUNT)) bus ();
  rename_tag_allocator #(.XLEN(32), .RN_COUNT(RN_COUNT)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int passed = 0;
  int total  = 0;

  // Model: free list in pop order, tags popped since the checkpoint, and committed tags that may be freed.
  int         free_q[$];
  int         spec_q[$];
  int         retire_q[$];
  bit         m_ovf;
  logic [1:0] m_valid;
  int         m_tag0, m_tag1;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
  endtask

  task automatic idle();
    bus.alloc_req  = 2'b00;
    bus.free_valid = 2'b00;
    bus.free_tag_0 = '0;
    bus.free_tag_1 = '0;
    bus.checkpoint = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic model_reset();
    free_q.delete();
    spec_q.delete();
    retire_q.delete();
    for (int t = 1; t < RN_COUNT; t++) free_q.push_back(t);
    m_ovf   = 1'b0;
    m_valid = 2'b00;
    m_tag0  = 0;
    m_tag1  = 0;
  endtask

  task automatic cycle(input logic [1:0] req, input logic [1:0] fv, input int t0, input int t1,
                       input bit ck, input bit fl, input string name);
    int  need, base, acc;
    bit  stall_exp;
    int  popped[$];
    int  ft[2];
    bus.alloc_req  = req;
    bus.free_valid = fv;
    bus.free_tag_0 = TW'(t0);
    bus.free_tag_1 = TW'(t1);
    bus.checkpoint = ck;
    bus.flush      = fl;
    #1;
    need      = int'(req[0]) + int'(req[1]);
    stall_exp = need > free_q.size();
    chk({name, " stall"}, bus.stall, stall_exp);
    base = fl ? free_q.size() + spec_q.size() : free_q.size();
    if (!fl && !stall_exp) begin
      if (req[0]) begin m_tag0 = free_q.pop_front(); popped.push_back(m_tag0); end
      if (req[1]) begin m_tag1 = free_q.pop_front(); popped.push_back(m_tag1); end
      m_valid = req;
    end else begin
      m_valid = 2'b00;
    end
    if (fl) begin
      free_q = {spec_q, free_q};
      spec_q.delete();
    end
    ft[0] = t0;
    ft[1] = t1;
    acc = 0;
    for (int i = 0; i < 2; i++) begin
      if (fv[i] && ft[i] != 0) begin
        if (base + acc < DEPTH) begin
          free_q.push_back(ft[i]);
          acc++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    if (!fl) begin
      if (ck) begin
        retire_q = {retire_q, spec_q, popped};
        spec_q.delete();
      end else begin
        spec_q = {spec_q, popped};
      end
    end
    @(posedge clock);
    #1;
    idle();
    chk({name, " alloc_valid"}, bus.alloc_valid, m_valid);
    chk({name, " alloc_tag_0"}, bus.alloc_tag_0, m_tag0);
    chk({name, " alloc_tag_1"}, bus.alloc_tag_1, m_tag1);
    chk({name, " free_count"}, bus.free_count, free_q.size());
    chk({name, " overflow"}, bus.overflow, m_ovf);
    chk({name, " ready"}, bus.ready, 1);
  endtask

  task automatic reset_and_init();
    bit early;
    reset = 1'b0;
    idle();
    repeat (3) @(posedge clock);
    #1;
    chk("reset alloc_valid", bus.alloc_valid, 0);
    chk("reset free_count", bus.free_count, 0);
    chk("reset ready", bus.ready, 0);
    reset = 1'b1;
    model_reset();
    early = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      @(posedge clock);
      #1;
      if (i < DEPTH && (bus.ready !== 1'b0 || bus.stall !== 1'b1)) early = 1'b1;
    end
    chk("init busy phase", early, 0);
    chk("init ready", bus.ready, 1);
    chk("init free_count", bus.free_count, 63);
    chk("init stall", bus.stall, 0);
    chk("init overflow", bus.overflow, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int       t, u, idx;
    logic [1:0] req, fv;
    bit       ck, fl;

    reset_and_init();

    cycle(2'b11, 2'b00, 0, 0, 0, 0, "dual");
    chk("dual tag0 const", bus.alloc_tag_0, 1);
    chk("dual tag1 const", bus.alloc_tag_1, 2);
    chk("dual count const", bus.free_count, 61);
    cycle(2'b10, 2'b00, 0, 0, 0, 0, "slot1");
    chk("slot1 tag const", bus.alloc_tag_1, 3);

    cycle(2'b11, 2'b00, 0, 0, 1, 0, "ckpt");
    chk("ckpt tags const", {bus.alloc_tag_0, bus.alloc_tag_1}, {6'd4, 6'd5});
    cycle(2'b11, 2'b00, 0, 0, 0, 0, "spec67");
    cycle(2'b01, 2'b00, 0, 0, 0, 0, "spec8");
    cycle(2'b00, 2'b00, 0, 0, 0, 1, "flush");
    chk("flush count const", bus.free_count, 58);
    cycle(2'b01, 2'b00, 0, 0, 0, 0, "realloc");
    chk("realloc tag const", bus.alloc_tag_0, 6);
    cycle(2'b11, 2'b00, 0, 0, 0, 1, "flush+alloc");
    chk("flush+alloc valid const", bus.alloc_valid, 0);

    while (free_q.size() > 1)
      cycle(free_q.size() >= 3 ? 2'b11 : 2'b01, 2'b00, 0, 0, 0, 0, "drain");
    cycle(2'b11, 2'b00, 0, 0, 0, 0, "exhaust");
    chk("exhaust count const", bus.free_count, 1);
    cycle(2'b01, 2'b00, 0, 0, 0, 0, "last");
    chk("last count const", bus.free_count, 0);
    t = retire_q.pop_front();
    cycle(2'b01, 2'b01, t, 0, 0, 0, "empty+free");
    chk("empty+free valid const", bus.alloc_valid, 0);
    cycle(2'b01, 2'b00, 0, 0, 0, 0, "refill");
    chk("refill tag", bus.alloc_tag_0, t);

    cycle(2'b00, 2'b00, 0, 0, 1, 0, "commit");
    cycle(2'b00, 2'b01, 0, 0, 0, 0, "free zero");
    while (retire_q.size() > 0) begin
      t = retire_q.pop_front();
      if (retire_q.size() > 0) begin
        u = retire_q.pop_front();
        cycle(2'b00, 2'b11, t, u, 0, 0, "release");
      end else begin
        cycle(2'b00, 2'b11, 0, t, 0, 0, "release");
      end
    end
    chk("full count const", bus.free_count, 63);
    chk("no overflow yet", bus.overflow, 0);
    cycle(2'b00, 2'b01, 5, 0, 0, 0, "overflow");
    chk("overflow const", bus.overflow, 1);
    chk("overflow count const", bus.free_count, 63);

    for (int n = 0; n < 500; n++) begin
      req = 2'($urandom_range(0, 3));
      ck  = ($urandom_range(0, 7) == 0);
      fl  = ($urandom_range(0, 11) == 0);
      fv  = 2'b00;
      t   = 0;
      u   = 0;
      if (retire_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        idx = $urandom_range(0, retire_q.size() - 1);
        t = retire_q[idx];
        retire_q.delete(idx);
        fv[0] = 1'b1;
      end else if ($urandom_range(0, 9) == 0) begin
        fv[0] = 1'b1;
      end
      if (retire_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        idx = $urandom_range(0, retire_q.size() - 1);
        u = retire_q[idx];
        retire_q.delete(idx);
        fv[1] = 1'b1;
      end
      cycle(req, fv, t, u, ck, fl, "rand");
    end

    #2;
    reset = 1'b0;
    #1;
    chk("async alloc_valid", bus.alloc_valid, 0);
    chk("async tags", {bus.alloc_tag_0, bus.alloc_tag_1}, 0);
    chk("async free_count", bus.free_count, 0);
    chk("async ready", bus.ready, 0);
    chk("async overflow", bus.overflow, 0);
    reset_and_init();
    cycle(2'b11, 2'b00, 0, 0, 0, 0, "post reset");
    chk("post reset tags const", {bus.alloc_tag_0, bus.alloc_tag_1}, {6'd1, 6'd2});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
